// File: rtl/dequant_pkg.sv
// Shared constants, types and helpers for the per-channel dequantizer.
// Constants below describe the default build (FRAC_BITS=16, OUT_W=32, 16 channels).
package dequant_pkg;

  localparam int DQ_NUM_CH    = 16;
  localparam int DQ_FRAC_BITS = 16;
  localparam int DQ_OUT_W     = 32;

  typedef logic [$clog2(DQ_NUM_CH)-1:0] ch_t;

  localparam logic [31:0] ROUND_K =
    32'd1 << (DQ_FRAC_BITS - 1);

  localparam logic signed [DQ_OUT_W-1:0] OUT_MAX =
    {1'b0, {(DQ_OUT_W-1){1'b1}}};

  localparam logic signed [DQ_OUT_W-1:0] OUT_MIN =
    {1'b1, {(DQ_OUT_W-1){1'b0}}};

  function automatic int dq_latency(input int mult_stages);
    return mult_stages + 2;
  endfunction

endpackage

// File: rtl/dequantize_pc_mult.sv
// Signed multiplier with MULT_STAGES output registers, shaped for DSP retiming.
// Ports: clk, rst_n (async low), en (advance), a, b (signed), p (full-width product).
module dq_mult_pipe #(
  parameter int IN_W        = 32,
  parameter int SCALE_W     = 32,
  parameter int MULT_STAGES = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic signed [IN_W-1:0]            a,
  input  logic signed [SCALE_W-1:0]         b,
  output logic signed [IN_W+SCALE_W-1:0]    p
);

  localparam int PW = IN_W + SCALE_W;

  logic signed [PW-1:0] ax;
  logic signed [PW-1:0] bx;
  logic signed [PW-1:0] st [MULT_STAGES];

  assign ax = $signed({{SCALE_W{a[IN_W-1]}}, a});
  assign bx = $signed({{IN_W{b[SCALE_W-1]}}, b});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        st[i] <= '0;
      end
    end else if (en) begin
      st[0] <= ax * bx;
      for (int i = 1; i < MULT_STAGES; i++) begin
        st[i] <= st[i-1];
      end
    end
  end

  assign p = st[MULT_STAGES-1];

endmodule

// File: rtl/dequantize_pc.sv
// Per-channel dequantizer: acc * scale[ch], round half-up, saturate, valid/ready.
// Ports: clk, rst_n, cfg_we/addr/data, in_valid/ready/data/ch, out_valid/ready/data/sat.
module dequantize_pc
  import dequant_pkg::*;
#(
  parameter int IN_W        = 32,
  parameter int SCALE_W     = 32,
  parameter int FRAC_BITS   = 16,
  parameter int OUT_W       = 32,
  parameter int NUM_CH      = 16,
  parameter int MULT_STAGES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]  cfg_addr,
  input  logic [SCALE_W-1:0]         cfg_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_W-1:0]     in_data,
  input  logic [$clog2(NUM_CH)-1:0]  in_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_sat
);

  localparam int PW = IN_W + SCALE_W;

  localparam logic signed [PW:0] RND =
    {{(PW+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [PW:0] HI =
    {{(PW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW:0] LO =
    {{(PW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] SAT_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN =
    {1'b1, {(OUT_W-1){1'b0}}};

  logic adv;

  logic signed [SCALE_W-1:0] tbl [NUM_CH];
  logic signed [SCALE_W-1:0] s_sel;

  logic                      v0;
  logic signed [IN_W-1:0]    d0;
  logic signed [SCALE_W-1:0] s0;

  logic [MULT_STAGES-1:0] vm;
  logic signed [PW-1:0]   prod;

  logic signed [PW:0]     sum;
  logic signed [PW:0]     r;
  logic signed [OUT_W-1:0] res;
  logic                   res_sat;

  // One global enable: the whole pipe moves only when the output slot frees.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tbl[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_addr) < NUM_CH)) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Read sees the pre-write table, so a same-cycle write hits the next beat.
  always_comb begin
    s_sel = '0;
    if (int'(in_ch) < NUM_CH) begin
      s_sel = tbl[in_ch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      d0 <= '0;
      s0 <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      if (in_valid) begin
        d0 <= in_data;
        s0 <= s_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vm <= '0;
    end else if (adv) begin
      vm <= (vm << 1) | MULT_STAGES'(v0);
    end
  end

  dq_mult_pipe #(
    .IN_W        (IN_W),
    .SCALE_W     (SCALE_W),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .a     (d0),
    .b     (s0),
    .p     (prod)
  );

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    sum     = {prod[PW-1], prod} + RND;
    r       = sum >>> FRAC_BITS;
    res     = r[OUT_W-1:0];
    res_sat = 1'b0;
    if (r > HI) begin
      res     = SAT_MAX;
      res_sat = 1'b1;
    end else if (r < LO) begin
      res     = SAT_MIN;
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= vm[MULT_STAGES-1];
      if (vm[MULT_STAGES-1]) begin
        out_data <= res;
        out_sat  <= res_sat;
      end
    end
  end

endmodule
